// File: rtl/morra_match_ctrl.sv
// morra_match_ctrl: first-to-N match controller in front of the MorraCinese core.
// Collects one move per player per round, drives START/config per game and scores results.
module morra_match_ctrl #(
   parameter int GAMES_W      = 3,
   parameter int MOVE_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               match_start,
   input  logic [3:0]         cfg_rounds,
   input  logic [GAMES_W-1:0] cfg_games,
   input  logic               p1_valid,
   input  logic [1:0]         p1_move,
   output logic               p1_ready,
   input  logic               p2_valid,
   input  logic [1:0]         p2_move,
   output logic               p2_ready,
   output logic [1:0]         core_p1,
   output logic [1:0]         core_p2,
   output logic               core_start,
   input  logic [1:0]         core_round,
   input  logic [1:0]         core_game,
   output logic [GAMES_W-1:0] p1_score,
   output logic [GAMES_W-1:0] p2_score,
   output logic               match_done,
   output logic [1:0]         match_winner,
   output logic               match_forfeit,
   output logic               busy
);

   localparam int                 CNT_W     = $clog2(MOVE_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(MOVE_TIMEOUT);
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [GAMES_W-1:0] SCORE_ONE = GAMES_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CFG,
      S_COLLECT,
      S_ISSUE,
      S_CHECK,
      S_DONE
   } state_e;

   state_e               state_q, state_d;
   logic [GAMES_W-1:0]   target_q, target_d;
   logic [GAMES_W-1:0]   p1_score_q, p1_score_d;
   logic [GAMES_W-1:0]   p2_score_q, p2_score_d;
   logic                 p1_have_q, p1_have_d;
   logic                 p2_have_q, p2_have_d;
   logic [1:0]           p1_mv_q, p1_mv_d;
   logic [1:0]           p2_mv_q, p2_mv_d;
   logic [CNT_W-1:0]     tmo_cnt_q, tmo_cnt_d;
   logic [1:0]           core_p1_q, core_p1_d;
   logic [1:0]           core_p2_q, core_p2_d;
   logic                 core_start_q, core_start_d;
   logic                 p1_ready_q, p1_ready_d;
   logic                 p2_ready_q, p2_ready_d;
   logic                 done_q, done_d;
   logic [1:0]           winner_q, winner_d;
   logic                 forfeit_q, forfeit_d;
   logic                 busy_q, busy_d;
   logic                 p1_take, p2_take;

   // ROUND is informational only; game outcome comes from GAME.
   logic unused_core_round;
   assign unused_core_round = ^core_round;

   always_comb begin
      // NOTE: every _d gets its hold value first so no path through the case infers a latch.
      state_d      = state_q;
      target_d     = target_q;
      p1_score_d   = p1_score_q;
      p2_score_d   = p2_score_q;
      p1_have_d    = p1_have_q;
      p2_have_d    = p2_have_q;
      p1_mv_d      = p1_mv_q;
      p2_mv_d      = p2_mv_q;
      tmo_cnt_d    = tmo_cnt_q;
      winner_d     = winner_q;
      forfeit_d    = forfeit_q;
      core_p1_d    = 2'b00;
      core_p2_d    = 2'b00;
      core_start_d = 1'b0;

      p1_take = p1_valid && p1_ready_q && (p1_move != 2'b00);
      p2_take = p2_valid && p2_ready_q && (p2_move != 2'b00);

      case (state_q)
         S_IDLE, S_DONE: begin
            if (match_start) begin
               state_d    = S_CFG;
               target_d   = (cfg_games == '0) ? SCORE_ONE : cfg_games;
               p1_score_d = '0;
               p2_score_d = '0;
               winner_d   = 2'b00;
               forfeit_d  = 1'b0;
            end
         end

         S_CFG: state_d = S_COLLECT;

         S_COLLECT: begin
            if (p1_take) begin
               p1_have_d = 1'b1;
               p1_mv_d   = p1_move;
            end
            if (p2_take) begin
               p2_have_d = 1'b1;
               p2_mv_d   = p2_move;
            end

            if (p1_have_d && p2_have_d) begin
               state_d   = S_ISSUE;
               p1_have_d = 1'b0;
               p2_have_d = 1'b0;
               tmo_cnt_d = '0;
            end else if (!p1_have_q && !p2_have_q) begin
               if (p1_have_d || p2_have_d) begin
                  tmo_cnt_d = CNT_ONE;
               end
            end else if (tmo_cnt_q == TMO_LAST) begin
               // The player who already submitted takes the match by forfeit.
               state_d   = S_DONE;
               forfeit_d = 1'b1;
               winner_d  = p1_have_q ? 2'b01 : 2'b10;
               p1_have_d = 1'b0;
               p2_have_d = 1'b0;
               tmo_cnt_d = '0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + CNT_ONE;
            end
         end

         S_ISSUE: state_d = S_CHECK;

         S_CHECK: begin
            case (core_game)
               2'b00: state_d = S_COLLECT;
               2'b01: begin
                  p1_score_d = p1_score_q + SCORE_ONE;
                  if (p1_score_d == target_q) begin
                     state_d  = S_DONE;
                     winner_d = 2'b01;
                  end else begin
                     state_d = S_CFG;
                  end
               end
               2'b10: begin
                  p2_score_d = p2_score_q + SCORE_ONE;
                  if (p2_score_d == target_q) begin
                     state_d  = S_DONE;
                     winner_d = 2'b10;
                  end else begin
                     state_d = S_CFG;
                  end
               end
               2'b11: state_d = S_CFG;
            endcase
         end

         default: state_d = S_IDLE;
      endcase

      // Outputs are registered, so they are decoded from the state being entered.
      if (state_d == S_CFG) begin
         core_start_d = 1'b1;
         core_p1_d    = cfg_rounds[3:2];
         core_p2_d    = cfg_rounds[1:0];
      end else if (state_d == S_ISSUE) begin
         core_p1_d = p1_mv_d;
         core_p2_d = p2_mv_d;
      end

      p1_ready_d = (state_d == S_COLLECT) && !p1_have_d;
      p2_ready_d = (state_d == S_COLLECT) && !p2_have_d;
      busy_d     = (state_d == S_CFG) || (state_d == S_COLLECT) ||
                   (state_d == S_ISSUE) || (state_d == S_CHECK);
      done_d     = (state_d == S_DONE);
   end

   // NOTE: flops use <= so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         target_q     <= SCORE_ONE;
         p1_score_q   <= '0;
         p2_score_q   <= '0;
         p1_have_q    <= 1'b0;
         p2_have_q    <= 1'b0;
         p1_mv_q      <= 2'b00;
         p2_mv_q      <= 2'b00;
         tmo_cnt_q    <= '0;
         core_p1_q    <= 2'b00;
         core_p2_q    <= 2'b00;
         core_start_q <= 1'b0;
         p1_ready_q   <= 1'b0;
         p2_ready_q   <= 1'b0;
         done_q       <= 1'b0;
         winner_q     <= 2'b00;
         forfeit_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         target_q     <= target_d;
         p1_score_q   <= p1_score_d;
         p2_score_q   <= p2_score_d;
         p1_have_q    <= p1_have_d;
         p2_have_q    <= p2_have_d;
         p1_mv_q      <= p1_mv_d;
         p2_mv_q      <= p2_mv_d;
         tmo_cnt_q    <= tmo_cnt_d;
         core_p1_q    <= core_p1_d;
         core_p2_q    <= core_p2_d;
         core_start_q <= core_start_d;
         p1_ready_q   <= p1_ready_d;
         p2_ready_q   <= p2_ready_d;
         done_q       <= done_d;
         winner_q     <= winner_d;
         forfeit_q    <= forfeit_d;
         busy_q       <= busy_d;
      end
   end

   assign core_p1       = core_p1_q;
   assign core_p2       = core_p2_q;
   assign core_start    = core_start_q;
   assign p1_ready      = p1_ready_q;
   assign p2_ready      = p2_ready_q;
   assign p1_score      = p1_score_q;
   assign p2_score      = p2_score_q;
   assign match_done    = done_q;
   assign match_winner  = winner_q;
   assign match_forfeit = forfeit_q;
   assign busy          = busy_q;

endmodule
